// File: rtl/de0_nano_onchip_mem_arbiter.sv
// Two-master round-robin arbiter in front of the single-port on-chip RAM.
// Grant and waitrequest are combinational; read responses return one cycle
// after acceptance. Out-of-range writes are dropped and out-of-range reads
// return zero.
module de0_nano_onchip_mem_arbiter #(
  parameter int unsigned ADDR_W   = 14,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUMWORDS = 11520
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W-1:0]     m0_writedata,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W-1:0]     m1_writedata,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic                  mem_clken,
  input  logic [DATA_W-1:0]     mem_readdata
);

  localparam int unsigned BE_W = DATA_W / 8;

  // last_grant_q: 0 = m0 won the last access, 1 = m1 won it
  logic              last_grant_q, last_grant_d;
  logic [1:0]        rd_pend_q, rd_pend_d;
  logic              rd_oor_q, rd_oor_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              m0_req_c, m1_req_c;
  logic              gnt0_c, gnt1_c, any_gnt_c;
  logic [ADDR_W-1:0] win_addr_c;
  logic [BE_W-1:0]   win_be_c;
  logic [DATA_W-1:0] win_wdata_c;
  logic              win_write_c, win_read_c, in_range_c;

  // Arbitration: the single requester wins; on contention the master that did not win last time wins
  always_comb begin
    m0_req_c    = m0_read | m0_write;
    m1_req_c    = m1_read | m1_write;
    gnt0_c      = reset_n & m0_req_c & (~m1_req_c | last_grant_q);
    gnt1_c      = reset_n & m1_req_c & (~m0_req_c | ~last_grant_q);
    any_gnt_c   = gnt0_c | gnt1_c;
    win_addr_c  = gnt1_c ? m1_address    : m0_address;
    win_be_c    = gnt1_c ? m1_byteenable : m0_byteenable;
    win_wdata_c = gnt1_c ? m1_writedata  : m0_writedata;
    win_write_c = gnt1_c ? m1_write      : m0_write;
    // a simultaneous read+write is treated as a write with no response
    win_read_c  = gnt1_c ? (m1_read & ~m1_write) : (m0_read & ~m0_write);
    in_range_c  = (32'(win_addr_c) < NUMWORDS);
  end

  // Next-state for grant history, read pipeline and held RAM bus values
  always_comb begin
    last_grant_d = last_grant_q;
    rd_pend_d    = 2'b00;
    rd_oor_d     = 1'b0;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    if (any_gnt_c) begin
      last_grant_d = gnt1_c;
      rd_pend_d    = {gnt1_c & win_read_c, gnt0_c & win_read_c};
      rd_oor_d     = win_read_c & ~in_range_c;
      addr_d       = win_addr_c;
      be_d         = win_be_c;
      wdata_d      = win_wdata_c;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_grant_q <= 1'b0;
      rd_pend_q    <= 2'b00;
      rd_oor_q     <= 1'b0;
      addr_q       <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rd_pend_q    <= rd_pend_d;
      rd_oor_q     <= rd_oor_d;
      addr_q       <= addr_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
    end
  end

  // Master-facing handshake and read response; everything is forced idle while reset_n is low
  always_comb begin
    m0_waitrequest   = ~reset_n | (m0_req_c & ~gnt0_c);
    m1_waitrequest   = ~reset_n | (m1_req_c & ~gnt1_c);
    m0_readdatavalid = reset_n & rd_pend_q[0];
    m1_readdatavalid = reset_n & rd_pend_q[1];
    m0_readdata      = (m0_readdatavalid & ~rd_oor_q) ? mem_readdata : '0;
    m1_readdata      = (m1_readdatavalid & ~rd_oor_q) ? mem_readdata : '0;
  end

  // RAM-facing drive; address/data hold their last value when nobody is granted
  always_comb begin
    mem_address    = any_gnt_c ? win_addr_c  : addr_q;
    mem_byteenable = any_gnt_c ? win_be_c    : be_q;
    mem_writedata  = any_gnt_c ? win_wdata_c : wdata_q;
    mem_chipselect = any_gnt_c;
    mem_write      = any_gnt_c & win_write_c & in_range_c;
    mem_clken      = reset_n;
  end

endmodule
